// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_add_pkg

// File: rtl/full_adder_cell.sv
// One-bit full adder used once per cycle by the serial adder.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule : full_adder_cell

// File: rtl/serial_add_ctrl.sv
// Bit-serial a+b+cin, LSB first, one full-adder step per cycle.
// Result and carry-out only update when the last bit has been processed.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_s;
  logic             fa_co;

  full_adder_cell u_fa (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // State register; reset aborts any in-flight addition.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath; DONE accepts a new start just like IDLE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_co;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_co;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC);
    done_d = (state_d == DONE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  logic [WIDTH:0] exp_res = '0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one addition with fixed-latency checks; noise pokes start/operands during CALC.
  task automatic do_add(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic tc, input logic [WIDTH:0] exp, input bit noise,
                        input string tag);
    start = 1'b1; a = ta; b = tb_v; cin = tc;
    tick();
    check_eq({tag, "_busy_acc"}, 64'(busy), 64'd1);
    for (int i = 1; i <= WIDTH; i++) begin
      if (noise) begin
        start = 1'b1; a = '0; b = '0; cin = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (i < WIDTH) begin
        check_eq({tag, "_busy"}, 64'(busy), 64'd1);
        check_eq({tag, "_nodone"}, 64'(done), 64'd0);
        check_eq({tag, "_held"}, 64'({cout, sum}), 64'(exp_res));
      end
    end
    check_eq({tag, "_done"}, 64'(done), 64'd1);
    check_eq({tag, "_busy_end"}, 64'(busy), 64'd0);
    check_eq({tag, "_res"}, 64'({cout, sum}), 64'(exp));
    exp_res = exp;
    start = 1'b0;
    tick();
    check_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
    check_eq({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dc;
    logic [WIDTH-1:0] ra, rb;
    logic             rc;

    // Reset with start asserted: must stay idle.
    rst = 1'b0; start = 1'b1; a = 8'h5A; b = 8'h33; cin = 1'b0;
    tick();
    tick();
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_sum", 64'(sum), 64'd0);
    check_eq("rst_cout", 64'(cout), 64'd0);

    // First edge with rst high accepts.
    rst = 1'b1;
    do_add(8'h5A, 8'h33, 1'b0, 9'h08D, 1'b0, "add_5a_33");
    do_add(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0, "add_ff_01");
    do_add(8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0, "add_ff_ff_1");
    do_add(8'h00, 8'h00, 1'b1, 9'h001, 1'b0, "add_00_00_1");
    do_add(8'h80, 8'h80, 1'b0, 9'h100, 1'b0, "add_80_80");

    // start and operand changes during CALC are ignored.
    dc = done_cnt;
    do_add(8'h5A, 8'h33, 1'b0, 9'h08D, 1'b1, "noise");
    check_eq("noise_single_done", 64'(done_cnt - dc), 64'd1);

    // Reset during the 4th CALC cycle aborts.
    start = 1'b1; a = 8'hFF; b = 8'h01; cin = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check_eq("abort_busy_pre", 64'(busy), 64'd1);
    dc = done_cnt;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_res = '0;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    check_eq("abort_sum", 64'(sum), 64'd0);
    check_eq("abort_cout", 64'(cout), 64'd0);
    for (int i = 0; i < 12; i++) tick();
    check_eq("abort_no_done", 64'(done_cnt - dc), 64'd0);
    check_eq("abort_idle", 64'(busy), 64'd0);

    // Back-to-back with start held high: period WIDTH+1.
    start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
    tick();
    a = 8'h10; b = 8'h20;
    for (int i = 1; i < WIDTH; i++) begin
      tick();
      check_eq("b2b_busy1", 64'(busy), 64'd1);
    end
    tick();
    check_eq("b2b_done1", 64'(done), 64'd1);
    check_eq("b2b_res1", 64'({cout, sum}), 64'h002);
    tick();
    check_eq("b2b_reaccept", 64'(busy), 64'd1);
    check_eq("b2b_done1_off", 64'(done), 64'd0);
    for (int i = 1; i < WIDTH; i++) begin
      tick();
      check_eq("b2b_hold1", 64'({cout, sum}), 64'h002);
      check_eq("b2b_nodone", 64'(done), 64'd0);
    end
    tick();
    check_eq("b2b_done2", 64'(done), 64'd1);
    check_eq("b2b_res2", 64'({cout, sum}), 64'h030);
    start = 1'b0;
    tick();
    check_eq("b2b_idle", 64'(busy), 64'd0);
    check_eq("b2b_hold2", 64'({cout, sum}), 64'h030);
    exp_res = 9'h030;

    // Random operands against a+b+cin.
    for (int n = 0; n < 1000; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      do_add(ra, rb, rc, (WIDTH+1)'(ra) + (WIDTH+1)'(rb) + (WIDTH+1)'(rc), 1'b0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_add_ctrl

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low (0 = reset, sampled on rising clk edge).
REQ-004 start  input  1  request to begin an addition; sampled at rising edge.
REQ-005 a  input  WIDTH  operand A; captured only on accepted start.
REQ-006 b  input  WIDTH  operand B; captured only on accepted start.
REQ-007 cin  input  1  carry-in; captured only on accepted start.
REQ-008 busy  output  1  high while bit-serial computation in progress.
REQ-009 done  output  1  one-cycle pulse; sum/cout valid and new.
REQ-010 sum  output  WIDTH  registered result, held until next completion or reset.
REQ-011 cout  output  1  registered carry-out, held like sum.

Function
REQ-012 The block SHALL add a+b+cin bit-serially, LSB first, using one 1-bit full-adder cell per cycle and a 1-bit carry register.
REQ-013 The FSM SHALL have states IDLE, CALC, DONE; reset state IDLE.
REQ-014 IDLE: start=1 at edge k SHALL load a, b into shift registers, carry<=cin, bit counter<=0, state<=CALC; start=0 stays IDLE.
REQ-015 CALC: each edge SHALL compute one sum bit from the operand LSBs and carry, shift it into the result shift register, update carry, shift operands right, increment counter.
REQ-016 CALC SHALL last exactly WIDTH cycles; at the edge processing bit WIDTH-1 (edge k+WIDTH), sum<=completed result, cout<=final carry, state<=DONE.
REQ-017 DONE: done=1 for exactly that one cycle (k+WIDTH to k+WIDTH+1); next edge -> IDLE, or -> CALC with new load if start=1 (back-to-back accept).
REQ-018 busy SHALL equal (state==CALC); done SHALL equal (state==DONE); both Moore outputs.
REQ-019 start while in CALC SHALL be ignored; no restart, no queuing.
REQ-020 Changes on a, b, cin outside the accepting edge SHALL have no effect on the result.
REQ-021 sum/cout SHALL change only at the CALC->DONE edge or at reset; intermediate bits never visible on sum.
REQ-022 Latency: start accepted at edge k -> done high in cycle after edge k+WIDTH; throughput one addition per WIDTH+1 cycles.
REQ-023 Result SHALL be the exact WIDTH+1-bit sum {cout,sum} = a+b+cin, including full wrap (all-ones + all-ones + 1).
REQ-024 Bit counter width SHALL be $clog2(WIDTH); no counter overflow for any legal WIDTH.

Reset
REQ-025 rst=0 at any edge, including mid-CALC, SHALL force state IDLE and abort the operation with no done pulse.
REQ-026 Reset values: busy=0, done=0, sum=0, cout=0, carry, counter and shift registers 0.
REQ-027 start coincident with rst=0 SHALL be ignored; first acceptance possible at first edge with rst=1.

Structure
REQ-028 Package serial_add_pkg SHALL hold the FSM state enum typedef (IDLE, CALC, DONE) and the default WIDTH constant.
REQ-029 The 1-bit sum/carry logic SHALL be a separate combinational sub-module full_adder_cell (inputs x, y, ci; outputs s, co); everything else in serial_add_ctrl.

Verification
REQ-030 WIDTH=8, a=0x5A, b=0x33, cin=0, start at edge k -> busy cycles k..k+7, done at k+8, sum=0x8D, cout=0.
REQ-031 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-032 start re-pulsed and a,b changed to 0x00 during CALC -> ignored; original 0x5A+0x33 result 0x8D delivered, single done pulse.
REQ-033 rst=0 for one edge at 4th CALC cycle -> next cycle busy=0, done=0, sum=0, cout=0; no done pulse afterwards.
REQ-034 start held high continuously with 0x01+0x01 then 0x10+0x20 -> done every 9 cycles, results 0x02 then 0x30, each held between pulses.
REQ-035 Self-checking scoreboard over 1000 random a, b, cin: {cout,sum} equals a+b+cin on every done pulse.
